// File: rtl/DisplayPkg.sv
// 640x480@60 display timing constants shared by the scan-out stage and the pixel drivers.
package DisplayPkg;

  localparam int unsigned CNT_W = 10;

  localparam int unsigned DISP_H_VISIBLE = 640;
  localparam int unsigned DISP_H_FRONT   = 16;
  localparam int unsigned DISP_H_SYNC    = 96;
  localparam int unsigned DISP_H_BACK    = 48;
  localparam int unsigned DISP_V_VISIBLE = 480;
  localparam int unsigned DISP_V_FRONT   = 10;
  localparam int unsigned DISP_V_SYNC    = 2;
  localparam int unsigned DISP_V_BACK    = 33;

  localparam int unsigned DISP_H_TOTAL =
      DISP_H_VISIBLE + DISP_H_FRONT + DISP_H_SYNC + DISP_H_BACK;
  localparam int unsigned DISP_V_TOTAL =
      DISP_V_VISIBLE + DISP_V_FRONT + DISP_V_SYNC + DISP_V_BACK;
  localparam int unsigned DISP_H_SYNC_START = DISP_H_VISIBLE + DISP_H_FRONT;
  localparam int unsigned DISP_V_SYNC_START = DISP_V_VISIBLE + DISP_V_FRONT;

  // Half-open window test lo <= val < hi, unsigned 10-bit.
  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enabled up-counter that wraps from MAX to 0 and flags the wrapping cycle.
module wrap_counter import DisplayPkg::*; #(
  parameter int unsigned MAX = DISP_H_TOTAL - 1,
  parameter int unsigned W   = CNT_W
) (
  input  logic         clk,
  input  logic         rst_l,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] MaxC = W'(MAX);

  logic [W-1:0] r_count;

  assign count = r_count;
  assign wrap  = en && (r_count == MaxC);

  // Count state: synchronous clear has priority over advance.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= wrap ? '0 : r_count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_scanout.sv
// VGA raster generator and registered scan-out of colour, sync and blank to the DAC.
module vga_scanout import DisplayPkg::*; #(
  parameter int unsigned H_VISIBLE = DISP_H_VISIBLE,
  parameter int unsigned H_FRONT   = DISP_H_FRONT,
  parameter int unsigned H_SYNC    = DISP_H_SYNC,
  parameter int unsigned H_BACK    = DISP_H_BACK,
  parameter int unsigned V_VISIBLE = DISP_V_VISIBLE,
  parameter int unsigned V_FRONT   = DISP_V_FRONT,
  parameter int unsigned V_SYNC    = DISP_V_SYNC,
  parameter int unsigned V_BACK    = DISP_V_BACK
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic [23:0] color_in,
  output logic [9:0]  VGA_row,
  output logic [9:0]  VGA_col,
  output logic [7:0]  VGA_R,
  output logic [7:0]  VGA_G,
  output logic [7:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N,
  output logic        VGA_CLK,
  output logic        frame_start,
  output logic        vblank
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CNT_W-1:0] HVisC    = CNT_W'(H_VISIBLE);
  localparam logic [CNT_W-1:0] HSyncLoC = CNT_W'(H_VISIBLE + H_FRONT);
  localparam logic [CNT_W-1:0] HSyncHiC = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [CNT_W-1:0] VVisC    = CNT_W'(V_VISIBLE);
  localparam logic [CNT_W-1:0] VSyncLoC = CNT_W'(V_VISIBLE + V_FRONT);
  localparam logic [CNT_W-1:0] VSyncHiC = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC);

  logic             r_pix_en;
  logic             r_vga_clk;
  logic             r_frame_start;
  logic [23:0]      r_rgb;
  logic             r_hs;
  logic             r_vs;
  logic             r_blank_n;

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_visible;
  logic             w_hs;
  logic             w_vs;
  logic [23:0]      w_rgb;

  wrap_counter #(
    .MAX (H_TOTAL - 1),
    .W   (CNT_W)
  ) u_h_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (r_pix_en),
    .clr   (1'b0),
    .count (w_h_cnt),
    .wrap  (w_h_wrap)
  );

  wrap_counter #(
    .MAX (V_TOTAL - 1),
    .W   (CNT_W)
  ) u_v_cnt (
    .clk   (clk),
    .rst_l (rst_l),
    .en    (w_h_wrap),
    .clr   (1'b0),
    .count (w_v_cnt),
    .wrap  (w_v_wrap)
  );

  // Decode visibility, sync windows and masked colour from the pre-edge counters.
  always_comb begin
    w_visible = (w_h_cnt < HVisC) && (w_v_cnt < VVisC);
    w_hs      = !in_window(w_h_cnt, HSyncLoC, HSyncHiC);
    w_vs      = !in_window(w_v_cnt, VSyncLoC, VSyncHiC);
    w_rgb     = w_visible ? color_in : 24'h0;
  end

  // Pixel-rate enable; VGA_CLK is held as the complement of it so its rise is mid-pixel.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_pix_en  <= 1'b0;
      r_vga_clk <= 1'b1;
    end else begin
      r_pix_en  <= ~r_pix_en;
      r_vga_clk <= r_pix_en;
    end
  end

  // Single output register keeps RGB, sync and blank aligned on the same tick.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_rgb     <= 24'h0;
      r_hs      <= 1'b1;
      r_vs      <= 1'b1;
      r_blank_n <= 1'b0;
    end else if (r_pix_en) begin
      r_rgb     <= w_rgb;
      r_hs      <= w_hs;
      r_vs      <= w_vs;
      r_blank_n <= w_visible;
    end
  end

  // One-clk pulse following the tick that wraps the raster back to (0,0).
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_h_wrap && w_v_wrap;
    end
  end

  assign VGA_col     = w_h_cnt;
  assign VGA_row     = w_v_cnt;
  assign VGA_R       = r_rgb[23:16];
  assign VGA_G       = r_rgb[15:8];
  assign VGA_B       = r_rgb[7:0];
  assign VGA_HS      = r_hs;
  assign VGA_VS      = r_vs;
  assign VGA_BLANK_N = r_blank_n;
  assign VGA_SYNC_N  = 1'b0;
  assign VGA_CLK     = r_vga_clk;
  assign frame_start = r_frame_start;
  assign vblank      = (w_v_cnt >= VVisC);

endmodule

// File: tb/tb_vga_scanout.sv
// Directed bench for vga_scanout using a shrunken raster so whole frames fit the cycle budget.
module tb_vga_scanout;

  // Small raster: 15 pixels x 8 lines; visible 8x4; HS low cols 10..12; VS low rows 5..6.
  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HSW = 3;
  localparam int HB = 2;
  localparam int VV = 4;
  localparam int VF = 1;
  localparam int VSW = 2;
  localparam int VB = 1;
  localparam int HT = 15;
  localparam int VT = 8;
  localparam int FT = 120;

  logic        clk;
  logic        rst_l;
  logic [23:0] color_in;
  logic [9:0]  VGA_row;
  logic [9:0]  VGA_col;
  logic [7:0]  VGA_R;
  logic [7:0]  VGA_G;
  logic [7:0]  VGA_B;
  logic        VGA_HS;
  logic        VGA_VS;
  logic        VGA_BLANK_N;
  logic        VGA_SYNC_N;
  logic        VGA_CLK;
  logic        frame_start;
  logic        vblank;

  int mode;
  int n_checks;
  int n_fail;

  vga_scanout #(
    .H_VISIBLE (HV),
    .H_FRONT   (HF),
    .H_SYNC    (HSW),
    .H_BACK    (HB),
    .V_VISIBLE (VV),
    .V_FRONT   (VF),
    .V_SYNC    (VSW),
    .V_BACK    (VB)
  ) dut (
    .clk         (clk),
    .rst_l       (rst_l),
    .color_in    (color_in),
    .VGA_row     (VGA_row),
    .VGA_col     (VGA_col),
    .VGA_R       (VGA_R),
    .VGA_G       (VGA_G),
    .VGA_B       (VGA_B),
    .VGA_HS      (VGA_HS),
    .VGA_VS      (VGA_VS),
    .VGA_BLANK_N (VGA_BLANK_N),
    .VGA_SYNC_N  (VGA_SYNC_N),
    .VGA_CLK     (VGA_CLK),
    .frame_start (frame_start),
    .vblank      (vblank)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Graphics stand-in: coordinate pattern or solid white.
  always_comb begin
    color_in = 24'h0;
    if (mode != 0) color_in = 24'hFFFFFF;
    else           color_in = {6'b0, VGA_row[9:2], VGA_col};
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_row"}, 32'(VGA_row), 0);
    check_eq({tag, "_col"}, 32'(VGA_col), 0);
    check_eq({tag, "_rgb"}, 32'({VGA_R, VGA_G, VGA_B}), 0);
    check_eq({tag, "_hs"}, 32'(VGA_HS), 1);
    check_eq({tag, "_vs"}, 32'(VGA_VS), 1);
    check_eq({tag, "_blank_n"}, 32'(VGA_BLANK_N), 0);
    check_eq({tag, "_fs"}, 32'(frame_start), 0);
    check_eq({tag, "_vga_clk"}, 32'(VGA_CLK), 1);
    check_eq({tag, "_sync_n"}, 32'(VGA_SYNC_N), 0);
    check_eq({tag, "_vblank"}, 32'(vblank), 0);
  endtask

  // Checks every clk after a reset release against a closed-form raster model:
  // after k edges, p = k/2 pixels have elapsed and the output register holds pixel p-1.
  task automatic run_checked(input int n_clk);
    int p, q, c, r, fs_last, line_last, hs_run, vs_run;
    logic [9:0] r10, c10;
    logic vis, prev_hs, prev_vs, fall_seen;
    logic [9:0] prev_col;
    logic [23:0] exp_rgb;
    fs_last = 0; line_last = 0; hs_run = 0; vs_run = 0;
    prev_hs = 1'b1; prev_vs = 1'b1; fall_seen = 1'b0; prev_col = 10'd0;
    for (int k = 1; k <= n_clk; k++) begin
      @(negedge clk);
      p = k / 2;
      check_eq("col", 32'(VGA_col), 32'(p % HT));
      check_eq("row", 32'(VGA_row), 32'((p / HT) % VT));
      check_eq("vblank", 32'(vblank), 32'(((p / HT) % VT) >= VV));
      check_eq("vga_clk", 32'(VGA_CLK), 32'(k % 2 == 0));
      check_eq("sync_n", 32'(VGA_SYNC_N), 0);
      check_eq("frame_start", 32'(frame_start), 32'((k % 2 == 0) && (p > 0) && (p % FT == 0)));
      if (p == 0) begin
        check_eq("rgb0", 32'({VGA_R, VGA_G, VGA_B}), 0);
        check_eq("hs0", 32'(VGA_HS), 1);
        check_eq("vs0", 32'(VGA_VS), 1);
        check_eq("blank_n0", 32'(VGA_BLANK_N), 0);
      end else begin
        q = p - 1;
        c = q % HT;
        r = (q / HT) % VT;
        r10 = 10'(r);
        c10 = 10'(c);
        vis = (c < HV) && (r < VV);
        if (!vis)          exp_rgb = 24'h0;
        else if (mode != 0) exp_rgb = 24'hFFFFFF;
        else               exp_rgb = {6'b0, r10[9:2], c10};
        check_eq("rgb", 32'({VGA_R, VGA_G, VGA_B}), 32'(exp_rgb));
        check_eq("blank_n", 32'(VGA_BLANK_N), 32'(vis));
        check_eq("hs", 32'(VGA_HS), 32'(!((c >= HV + HF) && (c < HV + HF + HSW))));
        check_eq("vs", 32'(VGA_VS), 32'(!((r >= VV + VF) && (r < VV + VF + VSW))));
      end
      // Directed timing measurements.
      if (prev_hs && !VGA_HS) begin
        hs_run = 1;
        if (!fall_seen) check_eq("hs_fall_col", 32'(VGA_col), HV + HF + 1);
        fall_seen = 1'b1;
      end else if (!VGA_HS) begin
        hs_run++;
      end else if (!prev_hs) begin
        check_eq("hs_low_clk", 32'(hs_run), HSW * 2);
      end
      if (!VGA_VS) begin
        vs_run++;
      end else if (!prev_vs) begin
        check_eq("vs_low_clk", 32'(vs_run), VSW * HT * 2);
        vs_run = 0;
      end
      if (frame_start) begin
        if (fs_last > 0) check_eq("fs_period", 32'(k - fs_last), FT * 2);
        fs_last = k;
      end
      if (VGA_col == 10'd0 && prev_col != 10'd0) begin
        if (line_last > 0) check_eq("line_period", 32'(k - line_last), HT * 2);
        line_last = k;
      end
      prev_hs = VGA_HS;
      prev_vs = VGA_VS;
      prev_col = VGA_col;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    mode = 0;
    rst_l = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("por");
    rst_l = 1'b1;
    // Two frames plus part of a third, ending mid-frame at row 2.
    run_checked(560);
    // Asynchronous reset away from any clock edge.
    #3;
    rst_l = 1'b0;
    #1;
    check_reset_vals("async");
    @(negedge clk);
    check_reset_vals("held");
    mode = 1;
    @(negedge clk);
    rst_l = 1'b1;
    run_checked(260);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
